// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: registered main decoder driving the ID/EX control
// register. Inserts a bubble on load-use hazards, squashes on flush, and
// tracks a multi-cycle MULT/DIV unit.
// Optional feature macro: CTRL_MULDIV_EN (MULT/DIV/MFHI/MFLO decode, MD
// hazard, MD busy FSM and countdown counter). Undefined: those functs decode
// as plain R-type and ex_muldiv/md_busy stay 0.
module ctrl_pipe_hazard #(
    parameter int unsigned OPW    = 6,
    parameter int unsigned FNW    = 6,
    parameter int unsigned RAW    = 5,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CW     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           id_valid,
    input  logic [OPW-1:0] instruccion,
    input  logic [FNW-1:0] funcion,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           flush,
    output logic           ex_RegDst,
    output logic           ex_Branch,
    output logic           ex_MemRead,
    output logic           ex_MemtoReg,
    output logic           ex_MemWrite,
    output logic           ex_ALUSrc,
    output logic           ex_RegWrite,
    output logic           ex_jump,
    output logic           ex_shiftC,
    output logic           ex_muldiv,
    output logic [1:0]     ex_ALUOp,
    output logic [RAW-1:0] ex_rt,
    output logic           stall,
    output logic           md_busy
);

    typedef struct packed {
        logic       RegDst;
        logic       Branch;
        logic       MemRead;
        logic       MemtoReg;
        logic       MemWrite;
        logic       ALUSrc;
        logic       RegWrite;
        logic       jump;
        logic       shiftC;
        logic       muldiv;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    localparam logic [FNW-1:0] FN_SLL   = FNW'(6'b000000);
    localparam logic [FNW-1:0] FN_SRL   = FNW'(6'b000010);
    localparam logic [FNW-1:0] FN_SRA   = FNW'(6'b000011);

    // Parameter sanity: latency must be at least 2 and fit the counter.
    if (MD_LAT < 2 || MD_LAT > (2 ** CW) - 1) begin : g_bad_md_cfg
        $error("ctrl_pipe_hazard: MD_LAT must be in [2, 2**CW-1]");
    end

    ctrl_t w_dec;
    ctrl_t r_ex;
    logic  w_ld_haz;
    logic  w_md_haz;

`ifdef CTRL_MULDIV_EN
    localparam logic [FNW-1:0] FN_MULT  = FNW'(6'b011000);
    localparam logic [FNW-1:0] FN_DIV   = FNW'(6'b011010);
    localparam logic [FNW-1:0] FN_MFHI  = FNW'(6'b010000);
    localparam logic [FNW-1:0] FN_MFLO  = FNW'(6'b010010);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } md_state_t;

    md_state_t     r_md_state;
    logic [CW-1:0] r_md_cnt;
    logic          w_mfx;
`endif

    // Combinational decode of the instruction sitting in ID.
    always_comb begin
        w_dec = '0;
`ifdef CTRL_MULDIV_EN
        w_mfx = 1'b0;
`endif
        case (instruccion)
            OP_RTYPE: begin
                w_dec.RegDst   = 1'b1;
                w_dec.RegWrite = 1'b1;
                w_dec.ALUOp    = 2'b10;
                w_dec.shiftC   = (funcion == FN_SLL) || (funcion == FN_SRL) ||
                                 (funcion == FN_SRA);
`ifdef CTRL_MULDIV_EN
                if (funcion == FN_MULT || funcion == FN_DIV) begin
                    w_dec.muldiv   = 1'b1;
                    w_dec.RegWrite = 1'b0;
                end
                w_mfx = (funcion == FN_MFHI) || (funcion == FN_MFLO);
`endif
            end
            OP_LW, OP_LB: begin
                w_dec.ALUSrc   = 1'b1;
                w_dec.MemRead  = 1'b1;
                w_dec.MemtoReg = 1'b1;
                w_dec.RegWrite = 1'b1;
                w_dec.ALUOp    = 2'b00;
            end
            OP_SW: begin
                w_dec.ALUSrc   = 1'b1;
                w_dec.MemWrite = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_dec.Branch = 1'b1;
                w_dec.ALUOp  = 2'b01;
            end
            OP_J: begin
                w_dec.jump = 1'b1;
            end
            default: w_dec = '0;
        endcase
    end

    // A load in EX whose (nonzero) destination feeds the ID instruction.
    assign w_ld_haz = r_ex.MemRead && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt)) && id_valid;

`ifdef CTRL_MULDIV_EN
    assign w_md_haz = id_valid && (w_dec.muldiv || w_mfx) &&
                      (md_busy || r_ex.muldiv);

    // MD busy FSM: runs off ex_muldiv regardless of enable or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_state <= ST_IDLE;
            r_md_cnt   <= '0;
        end else begin
            case (r_md_state)
                ST_IDLE: begin
                    if (r_ex.muldiv) begin
                        r_md_state <= ST_BUSY;
                        r_md_cnt   <= CW'(MD_LAT - 1);
                    end
                end
                ST_BUSY: begin
                    if (r_md_cnt == CW'(1)) begin
                        r_md_state <= ST_IDLE;
                        r_md_cnt   <= '0;
                    end else begin
                        r_md_cnt <= r_md_cnt - CW'(1);
                    end
                end
                default: begin
                    r_md_state <= ST_IDLE;
                    r_md_cnt   <= '0;
                end
            endcase
        end
    end

    assign md_busy = (r_md_state == ST_BUSY);
`else
    assign w_md_haz = 1'b0;
    assign md_busy  = 1'b0;
`endif

    assign stall = (w_ld_haz || w_md_haz) && !flush;

    // ID/EX register: flush, hold-off, stall or empty slot all load a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            ex_rt <= '0;
        end else if (flush || !enable || stall || !id_valid) begin
            r_ex  <= '0;
            ex_rt <= '0;
        end else begin
            r_ex  <= w_dec;
            ex_rt <= id_rt;
        end
    end

    assign ex_RegDst   = r_ex.RegDst;
    assign ex_Branch   = r_ex.Branch;
    assign ex_MemRead  = r_ex.MemRead;
    assign ex_MemtoReg = r_ex.MemtoReg;
    assign ex_MemWrite = r_ex.MemWrite;
    assign ex_ALUSrc   = r_ex.ALUSrc;
    assign ex_RegWrite = r_ex.RegWrite;
    assign ex_jump     = r_ex.jump;
    assign ex_shiftC   = r_ex.shiftC;
    assign ex_muldiv   = r_ex.muldiv;
    assign ex_ALUOp    = r_ex.ALUOp;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: directed vectors for ctrl_pipe_hazard with
// hand-computed expected control words. Covers both CTRL_MULDIV_EN builds.
module tb_ctrl_pipe_hazard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       id_valid;
    logic [5:0] instruccion;
    logic [5:0] funcion;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       flush;
    logic       ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite;
    logic       ex_ALUSrc, ex_RegWrite, ex_jump, ex_shiftC, ex_muldiv;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_rt;
    logic       stall;
    logic       md_busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Control word order:
    // RegDst Branch MemRead MemtoReg MemWrite ALUSrc RegWrite jump shiftC muldiv ALUOp[1:0]
    localparam logic [11:0] CW_ZERO = 12'b0000_0000_0000;
    localparam logic [11:0] CW_ADD  = 12'b1000_0010_0010;
    localparam logic [11:0] CW_SLL  = 12'b1000_0010_1010;
    localparam logic [11:0] CW_LW   = 12'b0011_0110_0000;
    localparam logic [11:0] CW_SW   = 12'b0000_1100_0000;
    localparam logic [11:0] CW_BR   = 12'b0100_0000_0001;
    localparam logic [11:0] CW_J    = 12'b0000_0001_0000;
`ifdef CTRL_MULDIV_EN
    localparam logic [11:0] CW_MULT = 12'b1000_0000_0110;
`else
    localparam logic [11:0] CW_MULT = 12'b1000_0010_0010;
`endif

    logic [11:0] ex_vec;
    assign ex_vec = {ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
                     ex_ALUSrc, ex_RegWrite, ex_jump, ex_shiftC, ex_muldiv, ex_ALUOp};

    ctrl_pipe_hazard #(
        .OPW    (6),
        .FNW    (6),
        .RAW    (5),
        .MD_LAT (4),
        .CW     (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .id_valid    (id_valid),
        .instruccion (instruccion),
        .funcion     (funcion),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .flush       (flush),
        .ex_RegDst   (ex_RegDst),
        .ex_Branch   (ex_Branch),
        .ex_MemRead  (ex_MemRead),
        .ex_MemtoReg (ex_MemtoReg),
        .ex_MemWrite (ex_MemWrite),
        .ex_ALUSrc   (ex_ALUSrc),
        .ex_RegWrite (ex_RegWrite),
        .ex_jump     (ex_jump),
        .ex_shiftC   (ex_shiftC),
        .ex_muldiv   (ex_muldiv),
        .ex_ALUOp    (ex_ALUOp),
        .ex_rt       (ex_rt),
        .stall       (stall),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt);
        id_valid    = v;
        instruccion = op;
        funcion     = fn;
        id_rs       = rs;
        id_rt       = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        flush  = 1'b0;
        set_id(1'b0, 6'b0, 6'b0, 5'd0, 5'd0);
        #2;
        check_eq("reset_ex", 32'(ex_vec), 32'(CW_ZERO));
        check_eq("reset_rt", 32'(ex_rt), 32'd0);
        check_eq("reset_busy", 32'(md_busy), 32'd0);
        tick();
        rst_n = 1'b1;

        // Load-use: LW r5 then ADD rs=5
        set_id(1'b1, 6'b100011, 6'b0, 5'd1, 5'd5);
        #1 check_eq("lw_no_stall", 32'(stall), 32'd0);
        tick();
        check_eq("lw_ex", 32'(ex_vec), 32'(CW_LW));
        check_eq("lw_rt", 32'(ex_rt), 32'd5);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd2);
        #1 check_eq("lu_stall", 32'(stall), 32'd1);
        tick();
        check_eq("lu_bubble", 32'(ex_vec), 32'(CW_ZERO));
        check_eq("lu_bubble_rt", 32'(ex_rt), 32'd0);
        check_eq("lu_stall_clear", 32'(stall), 32'd0);
        tick();
        check_eq("add_ex", 32'(ex_vec), 32'(CW_ADD));
        check_eq("add_rt", 32'(ex_rt), 32'd2);

        // LW r0 then ADD rs=0: no hazard
        set_id(1'b1, 6'b100011, 6'b0, 5'd3, 5'd0);
        tick();
        check_eq("lw0_ex", 32'(ex_vec), 32'(CW_LW));
        set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0);
        #1 check_eq("lw0_no_stall", 32'(stall), 32'd0);
        tick();
        check_eq("lw0_add_ex", 32'(ex_vec), 32'(CW_ADD));

        // BEQ squashed by flush
        set_id(1'b1, 6'b000100, 6'b0, 5'd1, 5'd2);
        flush = 1'b1;
        tick();
        check_eq("flush_beq", 32'(ex_vec), 32'(CW_ZERO));
        flush = 1'b0;
        tick();
        check_eq("beq_ex", 32'(ex_vec), 32'(CW_BR));

        // Flush beats a concurrent load-use hazard
        set_id(1'b1, 6'b100000, 6'b0, 5'd1, 5'd7);
        tick();
        check_eq("lb_ex", 32'(ex_vec), 32'(CW_LW));
        set_id(1'b1, 6'b000000, 6'b100000, 5'd4, 5'd7);
        #1 check_eq("lu_rt_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1 check_eq("flush_stall", 32'(stall), 32'd0);
        tick();
        check_eq("flush_lu_ex", 32'(ex_vec), 32'(CW_ZERO));
        flush = 1'b0;

        // Decode table sweep
        set_id(1'b1, 6'b000000, 6'b000000, 5'd1, 5'd2);
        tick();
        check_eq("sll_ex", 32'(ex_vec), 32'(CW_SLL));
        set_id(1'b1, 6'b000010, 6'b0, 5'd0, 5'd0);
        tick();
        check_eq("j_ex", 32'(ex_vec), 32'(CW_J));
        set_id(1'b1, 6'b111111, 6'b0, 5'd0, 5'd9);
        tick();
        check_eq("bad_op_ex", 32'(ex_vec), 32'(CW_ZERO));
        set_id(1'b1, 6'b101011, 6'b0, 5'd1, 5'd3);
        tick();
        check_eq("sw_ex", 32'(ex_vec), 32'(CW_SW));
        check_eq("sw_rt", 32'(ex_rt), 32'd3);
        set_id(1'b1, 6'b000101, 6'b0, 5'd1, 5'd3);
        tick();
        check_eq("bne_ex", 32'(ex_vec), 32'(CW_BR));

        // Empty slot and pipeline hold both load a bubble
        set_id(1'b0, 6'b000000, 6'b100000, 5'd1, 5'd2);
        tick();
        check_eq("invalid_ex", 32'(ex_vec), 32'(CW_ZERO));
        set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2);
        enable = 1'b0;
        tick();
        check_eq("hold_ex", 32'(ex_vec), 32'(CW_ZERO));
        enable = 1'b1;
        tick();
        check_eq("resume_ex", 32'(ex_vec), 32'(CW_ADD));

        // MULT then MFLO
        set_id(1'b1, 6'b000000, 6'b011000, 5'd1, 5'd2);
        #1 check_eq("mult_no_stall", 32'(stall), 32'd0);
        tick();
        check_eq("mult_ex", 32'(ex_vec), 32'(CW_MULT));
        check_eq("mult_busy0", 32'(md_busy), 32'd0);
        set_id(1'b1, 6'b000000, 6'b010010, 5'd0, 5'd0);
`ifdef CTRL_MULDIV_EN
        #1 check_eq("mflo_stall_ex", 32'(stall), 32'd1);
        for (int unsigned i = 1; i <= 3; i++) begin
            tick();
            check_eq($sformatf("md_busy_c%0d", i), 32'(md_busy), 32'd1);
            check_eq($sformatf("mflo_stall_c%0d", i), 32'(stall), 32'd1);
            check_eq($sformatf("md_bubble_c%0d", i), 32'(ex_vec), 32'(CW_ZERO));
        end
        tick();
        check_eq("md_idle", 32'(md_busy), 32'd0);
        check_eq("mflo_release", 32'(stall), 32'd0);
        tick();
        check_eq("mflo_ex", 32'(ex_vec), 32'(CW_ADD));

        // MULT then DIV: no overlap
        set_id(1'b1, 6'b000000, 6'b011000, 5'd1, 5'd2);
        tick();
        set_id(1'b1, 6'b000000, 6'b011010, 5'd3, 5'd4);
        #1 check_eq("div_stall", 32'(stall), 32'd1);
        tick();
        check_eq("div_busy", 32'(md_busy), 32'd1);

        // Asynchronous reset mid-BUSY
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(md_busy), 32'd0);
        check_eq("arst_ex", 32'(ex_vec), 32'(CW_ZERO));
        check_eq("arst_stall", 32'(stall), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check_eq("post_rst_div_ex", 32'(ex_vec), 32'(CW_MULT & 12'b1111_1111_1111));
        check_eq("post_rst_muldiv", 32'(ex_muldiv), 32'd1);
`else
        #1 check_eq("mflo_no_stall", 32'(stall), 32'd0);
        tick();
        check_eq("mflo_ex", 32'(ex_vec), 32'(CW_ADD));
        check_eq("nomd_busy", 32'(md_busy), 32'd0);
        check_eq("nomd_muldiv", 32'(ex_muldiv), 32'd0);

        // Asynchronous reset with live ID/EX contents
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_ex", 32'(ex_vec), 32'(CW_ZERO));
        check_eq("arst_rt", 32'(ex_rt), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check_eq("post_rst_ex", 32'(ex_vec), 32'(CW_ADD));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Registered, parametrised successor to the combinational main decoder. Decodes opcode/funct in ID and drives the ID/EX control register.
- Detects load-use hazards and inserts bubbles on them.
- Squashes on branch/jump flush.
- Tracks a multi-cycle MULT/DIV unit with a busy FSM, stalling dependent instructions.

Parameters:
- OPW, 6, opcode width
- FNW, 6, funct width
- RAW, 5, register-address width
- MD_LAT, 4, MULT/DIV latency in cycles (≥2)
- CW, 4, MD countdown counter width; MD_LAT ≤ 2^CW-1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  pipeline advance; 0 loads bubble into ID/EX, FSM keeps counting
- id_valid  in  1  IF/ID holds a real instruction
- instruccion  in  OPW  opcode in ID
- funcion  in  FNW  funct in ID
- id_rs  in  RAW  rs of ID instruction
- id_rt  in  RAW  rt of ID instruction
- flush  in  1  branch taken/jump resolved; squash ID
- ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_jump, ex_shiftC, ex_muldiv  out  1 each  registered ID/EX controls
- ex_ALUOp  out  2  registered ALU op class
- ex_rt  out  RAW  registered rt (load destination)
- stall  out  1  combinational; freeze PC and IF/ID
- md_busy  out  1  MULT/DIV in flight

Behaviour:
- Reset (async, rst_n=0): all ex_* = 0, ex_rt = 0, FSM = IDLE, counter = 0, md_busy = 0.
- Decode is combinational, with the existing truth table:
  - R-type 000000: RegDst=1, RegWrite=1, ALUOp=10; shiftC=1 for funct 000000/000010/000011.
  - LW 100011 and LB 100000: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=00.
  - SW 101011: ALUSrc=1, MemWrite=1.
  - BEQ 000100 and BNE 000101: Branch=1, ALUOp=01.
  - J 000010: jump=1.
  - Other opcodes: all 0.
- New R-type functs:
  - MULT 011000 and DIV 011010: muldiv=1, RegWrite=0.
  - MFHI 010000 and MFLO 010010: mfx (internal) = 1.
- Load-use hazard:
  - ld_haz = ex_MemRead & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & id_valid.
- MD hazard:
  - md_haz = id_valid & (muldiv | mfx) & (md_busy | ex_muldiv).
- stall = (ld_haz | md_haz) & ~flush.
- ID/EX update, each rising edge, in priority order:
  1. flush → bubble
  2. ~enable → bubble
  3. stall → bubble
  4. ~id_valid → bubble
  5. otherwise → decoded controls and id_rt
  - Bubble means all controls = 0 and ex_rt = 0.
  - Load-use bubble lasts exactly 1 cycle: the next cycle ex_MemRead = 0, so the hazard clears.
- MD FSM, states IDLE and BUSY:
  - IDLE→BUSY when ex_muldiv = 1 at the edge; counter loads MD_LAT-1.
  - In BUSY the counter decrements each edge. At counter = 1 → IDLE, counter = 0.
  - md_busy = (state == BUSY).
  - MULT/DIV occupies MD_LAT cycles counting its EX cycle.
  - flush does not abort BUSY, because the operation has already issued.
  - A MULT/DIV in ID during BUSY stalls until IDLE. No back-to-back overlap.
- Simultaneous flush and stall: flush wins. Bubble is loaded, stall = 0.
- Reset mid-BUSY: FSM returns to IDLE at once; md_busy = 0 asynchronously.
- Latency:
  - Decode → ex_* outputs: 1 cycle.
  - stall: 0 cycles (combinational).

Optional Feature:
- Macro: CTRL_MULDIV_EN.
- Defined: MULT/DIV/MFHI/MFLO decoding, md_haz, MD FSM and counter are present.
- Undefined:
  - The MULT/DIV/MFHI/MFLO functs decode as plain R-type (muldiv = 0).
  - ex_muldiv and md_busy are tied to 0.
  - stall = ld_haz & ~flush.
  - No FSM logic is synthesised.

Test Plan:
- Reset release, then LW (100011) rt=5 followed by ADD rs=5 → stall = 1 for exactly 1 cycle. ex_* = 0 in that cycle. ADD enters EX next with ex_RegDst = 1, ex_ALUOp = 10.
- LW rt=0 followed by ADD rs=0 → stall = 0; no bubble.
- BEQ in ID with flush = 1 → next cycle all ex_* = 0. flush plus a concurrent load-use hazard → stall = 0.
- MULT (funct 011000) with MD_LAT = 4, then MFLO → md_busy high 3 cycles after MULT in EX. MFLO stalled while ex_muldiv | md_busy. MFLO issues on the first cycle md_busy = 0.
- SLL (funct 000000) → ex_shiftC = 1. J → ex_jump = 1. Opcode 111111 → all zero.
- rst_n pulsed low mid-BUSY → md_busy = 0 and ex_* = 0 immediately, without waiting for a clock edge. With CTRL_MULDIV_EN undefined, MULT → ex_muldiv = 0, md_busy stays 0, no stall.
